// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Sequential shift-and-add-3 binary-to-BCD converter, one bit
//                per clock, with a start/busy/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  Clk,
    input  logic                  Clr,
    input  logic                  Start,
    input  logic [WIDTH-1:0]      Bin,
    output logic                  Busy,
    output logic                  Done,
    output logic [4*DIGITS-1:0]   Bcd
);

    localparam int c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t                r_state;
    logic [WIDTH-1:0]      r_shift;
    logic [4*DIGITS-1:0]   r_scratch;
    logic [c_cnt_w-1:0]    r_cnt;
    logic                  r_busy;
    logic                  r_done;
    logic [4*DIGITS-1:0]   r_bcd;

    logic [4*DIGITS-1:0]   w_adj;
    logic [4*DIGITS-1:0]   w_next_scratch;

    // Each digit >= 5 gets +3 so the following doubling carries correctly.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        logic [3:0] w_dig;
        assign w_dig               = r_scratch[4*gi +: 4];
        assign w_adj[4*gi +: 4]    = (w_dig >= 4'd5) ? (w_dig + 4'd3) : w_dig;
    end

    assign w_next_scratch = (w_adj << 1) | {{(4*DIGITS-1){1'b0}}, r_shift[WIDTH-1]};

    always_ff @(posedge Clk) begin
        if (Clr) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bcd     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_shift   <= Bin;
                        r_scratch <= '0;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_scratch <= w_next_scratch;
                    r_shift   <= r_shift << 1;
                    r_cnt     <= r_cnt + 1'b1;
                    // Bcd is only ever loaded with a finished result.
                    if (r_cnt == c_last) begin
                        r_bcd   <= w_next_scratch;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign Busy = r_busy;
    assign Done = r_done;
    assign Bcd  = r_bcd;

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bin2bcd_seq
//  Description : Self-checking bench for bin2bcd_seq (directed vectors plus a
//                counter-driven continuous run).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bin2bcd_seq;

    logic        clk;
    logic        clr;
    logic        start_drv;
    logic [15:0] bin_drv;
    logic        cnt_mode;
    logic        start;
    logic [15:0] bin;
    logic        busy;
    logic        done;
    logic [19:0] bcd;

    logic [15:0] cnt_q;
    logic        cnt_load;
    logic [15:0] cnt_val;

    int checks;
    int errors;
    int done_count;
    bit chk_en;

    assign start = start_drv | cnt_mode;
    assign bin   = cnt_mode ? cnt_q : bin_drv;

    bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
        .Clk   (clk),
        .Clr   (clr),
        .Start (start),
        .Bin   (bin),
        .Busy  (busy),
        .Done  (done),
        .Bcd   (bcd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running counter standing in for the upstream 16-bit counter.
    always @(posedge clk) begin
        if (cnt_load) cnt_q <= cnt_val;
        else          cnt_q <= cnt_q + 16'd1;
    end

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        r = '0;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Handshake model: captures Bin on accepting edges, predicts Done timing.
    logic [15:0] m_q[$];
    bit          m_busy;
    int          m_left;
    bit          m_done;

    always @(posedge clk) begin
        m_done = 1'b0;
        if (clr) begin
            m_busy = 1'b0;
            m_left = 0;
            m_q.delete();
        end else if (!m_busy) begin
            if (start) begin
                m_q.push_back(bin);
                m_busy = 1'b1;
                m_left = 16;
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_done", {31'd0, done}, {31'd0, m_done});
            check("model_busy", {31'd0, busy}, {31'd0, m_busy});
            if (done) begin
                done_count++;
                if (m_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL model_queue: got Done with no pending request, expected none");
                end else begin
                    check("model_bcd", {12'd0, bcd}, {12'd0, to_bcd(int'(m_q.pop_front()))});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [15:0] v);
        start_drv = 1'b1;
        bin_drv   = v;
        tick();
        start_drv = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done) begin
                n = i;
                break;
            end
        end
        if (n == 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no Done in 40 cycles, expected Done");
        end
    endtask

    task automatic convert(input logic [15:0] v, input logic [19:0] exp, input string name);
        int n;
        int busy_n;
        start_drv = 1'b1;
        bin_drv   = v;
        tick();
        start_drv = 1'b0;
        busy_n = 0;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            if (busy) busy_n++;
            tick();
            if (done) begin
                n = i;
                break;
            end
        end
        check({name, "_latency"}, n, 16);
        check({name, "_busy_cycles"}, busy_n, 16);
        check({name, "_bcd"}, {12'd0, bcd}, {12'd0, exp});
        check({name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        tick();
        check({name, "_done_width"}, {31'd0, done}, 32'd0);
        check({name, "_bcd_hold"}, {12'd0, bcd}, {12'd0, exp});
    endtask

    typedef struct {
        logic [15:0] bin;
        logic [19:0] bcd;
        string       name;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int n;
        int m;
        int dc0;
        checks     = 0;
        errors     = 0;
        done_count = 0;
        chk_en     = 1'b0;
        clr        = 1'b1;
        start_drv  = 1'b0;
        bin_drv    = '0;
        cnt_mode   = 1'b0;
        cnt_load   = 1'b1;
        cnt_val    = '0;

        vecs[0]  = '{16'd0,     20'h00000, "zero"};
        vecs[1]  = '{16'hFFFF,  20'h65535, "max"};
        vecs[2]  = '{16'd1234,  20'h01234, "v1234"};
        vecs[3]  = '{16'd1,     20'h00001, "one"};
        vecs[4]  = '{16'd9,     20'h00009, "nine"};
        vecs[5]  = '{16'd10,    20'h00010, "ten"};
        vecs[6]  = '{16'd99,    20'h00099, "v99"};
        vecs[7]  = '{16'd100,   20'h00100, "v100"};
        vecs[8]  = '{16'd4095,  20'h04095, "v4095"};
        vecs[9]  = '{16'd32768, 20'h32768, "v32768"};
        vecs[10] = '{16'd59999, 20'h59999, "v59999"};
        vecs[11] = '{16'd40960, 20'h40960, "v40960"};

        tick();
        tick();
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_bcd",  {12'd0, bcd},  32'd0);
        clr    = 1'b0;
        chk_en = 1'b1;

        for (int i = 0; i < 12; i++) begin
            convert(vecs[i].bin, vecs[i].bcd, vecs[i].name);
        end

        // Back-to-back: second Start presented in the Done cycle.
        launch(16'd9999);
        wait_done(n);
        check("b2b_first_latency", n, 16);
        check("b2b_first_bcd", {12'd0, bcd}, 32'h09999);
        start_drv = 1'b1;
        bin_drv   = 16'd10000;
        tick();
        start_drv = 1'b0;
        m = 1;
        for (int i = 0; i < 40 && !done; i++) begin
            check("b2b_hold", {12'd0, bcd}, 32'h09999);
            tick();
            m++;
        end
        check("b2b_second_spacing", m, 17);
        check("b2b_second_bcd", {12'd0, bcd}, 32'h10000);
        tick();
        check("b2b_done_width", {31'd0, done}, 32'd0);

        // Start and Bin changes while busy are ignored.
        dc0 = done_count;
        launch(16'd500);
        repeat (5) tick();
        start_drv = 1'b1;
        bin_drv   = 16'd42;
        tick();
        start_drv = 1'b0;
        wait_done(n);
        check("busy_start_latency", 6 + n, 16);
        check("busy_start_bcd", {12'd0, bcd}, 32'h00500);
        repeat (20) tick();
        check("busy_start_one_done", done_count - dc0, 1);

        // Clr aborts an in-flight conversion without a Done.
        convert(16'd321, 20'h00321, "pre_abort");
        dc0 = done_count;
        launch(16'd777);
        repeat (7) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_bcd",  {12'd0, bcd},  32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        repeat (25) tick();
        check("abort_no_done", done_count - dc0, 0);
        convert(16'd777, 20'h00777, "post_abort");

        // Counter-driven continuous run.
        cnt_load = 1'b1;
        cnt_val  = 16'd0;
        tick();
        cnt_load = 1'b0;
        cnt_mode = 1'b1;
        dc0 = done_count;
        for (int i = 0; i < 1000 && (done_count - dc0) < 12; i++) tick();
        check("cnt_run_a_count", ((done_count - dc0) >= 12) ? 1 : 0, 1);
        cnt_val  = 16'd9990;
        cnt_load = 1'b1;
        tick();
        cnt_load = 1'b0;
        dc0 = done_count;
        for (int i = 0; i < 2000 && (done_count - dc0) < 40; i++) tick();
        check("cnt_run_b_count", ((done_count - dc0) >= 40) ? 1 : 0, 1);
        cnt_mode = 1'b0;
        repeat (20) tick();
        check("final_queue_empty", m_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
